// File: rtl/bsmac_seq_ctrl.sv
// bsmac_seq_ctrl
//   Sequencer for a bit-serial weighted-sum datapath. Holds one weight per lane,
//   accepts a job of N_LANES activations over valid/ready, and feeds the datapath
//   one activation bit-plane per cycle, MSB first. Each lane carries its weight when
//   the activation bit is set and zero otherwise. After one idle gap cycle it waits
//   for the datapath result and hands it to the requester over valid/ready. If no
//   result arrives within TIMEOUT cycles, the job is abandoned and a sticky error
//   flag is raised.
// Ports
//   clk, rst                       clock, async active-high reset
//   cfg_we/cfg_addr/cfg_wdata      weight write (honoured only while idle)
//   cfg_drop                       1-cycle pulse when a weight write was discarded
//   act_valid/act_ready/act_data   job input, lane k at [k*AW +: AW]
//   mac_valid/mac_lane             datapath drive, lane k at [k*WW +: WW]
//   mac_out_valid/mac_out          datapath result
//   res_valid/res_ready/res_data   result output
//   busy                           not idle
//   timeout_err                    sticky timeout flag
module bsmac_seq_ctrl #(
  parameter int unsigned N_LANES = 32,
  parameter int unsigned AW      = 4,
  parameter int unsigned WW      = 4,
  parameter int unsigned OW      = 13,
  parameter int unsigned TIMEOUT = 3000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(N_LANES)-1:0] cfg_addr,
  input  logic [WW-1:0]              cfg_wdata,
  output logic                       cfg_drop,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [N_LANES*AW-1:0]      act_data,
  output logic                       mac_valid,
  output logic [N_LANES*WW-1:0]      mac_lane,
  input  logic                       mac_out_valid,
  input  logic [OW-1:0]              mac_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OW-1:0]              res_data,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned BW  = (AW > 1) ? $clog2(AW) : 1;
  localparam int unsigned WCW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_WAIT, S_HOLD} state_e;

  state_e                state_q, state_d;
  logic [WW-1:0]         wgt_q [N_LANES];
  logic [WW-1:0]         wgt_d [N_LANES];
  logic [N_LANES*AW-1:0] act_q, act_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [WCW-1:0]        wait_q, wait_d;
  logic [OW-1:0]         res_q, res_d;
  logic                  terr_q, terr_d;
  logic                  drop_q, drop_d;
  logic [N_LANES*WW-1:0] lane_q, lane_d;
  logic                  act_ready_q, mac_valid_q, res_valid_q, busy_q;

  always_comb begin
    logic [AW-1:0] a_k;
    state_d = state_q;
    wgt_d   = wgt_q;
    act_d   = act_q;
    bit_d   = bit_q;
    wait_d  = wait_q;
    res_d   = res_q;
    terr_d  = terr_q;
    drop_d  = 1'b0;
    lane_d  = '0;
    a_k     = '0;

    if (cfg_we) begin
      if (state_q == S_IDLE) wgt_d[cfg_addr] = cfg_wdata;
      else                   drop_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (act_valid && act_ready_q) begin
          act_d   = act_data;
          bit_d   = BW'(AW - 1);
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (bit_q == '0) state_d = S_GAP;
        else             bit_d   = bit_q - 1'b1;
      end
      S_GAP: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mac_out_valid) begin
          res_d   = mac_out;
          state_d = S_HOLD;
        end else if (wait_q >= WCW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Lanes are registered, so they are built from next-state values; this also
    // lets a weight written on the accept edge reach the first plane of that job.
    if (state_d == S_SEND) begin
      for (int unsigned k = 0; k < N_LANES; k++) begin
        a_k = act_d[k*AW +: AW];
        lane_d[k*WW +: WW] = wgt_d[k] & {WW{a_k[bit_d]}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int unsigned k = 0; k < N_LANES; k++) wgt_q[k] <= '0;
      act_q       <= '0;
      bit_q       <= '0;
      wait_q      <= '0;
      res_q       <= '0;
      terr_q      <= 1'b0;
      drop_q      <= 1'b0;
      lane_q      <= '0;
      act_ready_q <= 1'b0;
      mac_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wgt_q       <= wgt_d;
      act_q       <= act_d;
      bit_q       <= bit_d;
      wait_q      <= wait_d;
      res_q       <= res_d;
      terr_q      <= terr_d;
      drop_q      <= drop_d;
      lane_q      <= lane_d;
      act_ready_q <= (state_d == S_IDLE);
      mac_valid_q <= (state_d == S_SEND);
      res_valid_q <= (state_d == S_HOLD);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign cfg_drop    = drop_q;
  assign act_ready   = act_ready_q;
  assign mac_valid   = mac_valid_q;
  assign mac_lane    = lane_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bsmac_seq_ctrl.sv
// tb_bsmac_seq_ctrl
//   Scoreboard bench for bsmac_seq_ctrl. Jobs push expected bit-planes and the
//   expected weighted sum (sum of weight*activation) into queues; monitors pop and
//   compare whenever the DUT drives a plane or completes a result handshake. A small
//   datapath stand-in accumulates the planes it sees and answers after a random delay.
module tb_bsmac_seq_ctrl;
  localparam int N  = 32;
  localparam int AW = 4;
  localparam int WW = 4;
  localparam int OW = 13;
  localparam int TO = 16;

  logic            clk, rst;
  logic            cfg_we;
  logic [4:0]      cfg_addr;
  logic [WW-1:0]   cfg_wdata;
  logic            cfg_drop;
  logic            act_valid, act_ready;
  logic [N*AW-1:0] act_data;
  logic            mac_valid;
  logic [N*WW-1:0] mac_lane;
  logic            mac_out_valid;
  logic [OW-1:0]   mac_out;
  logic            res_valid, res_ready;
  logic [OW-1:0]   res_data;
  logic            busy, timeout_err;

  bsmac_seq_ctrl #(.N_LANES(N), .AW(AW), .WW(WW), .OW(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_drop(cfg_drop),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .mac_valid(mac_valid), .mac_lane(mac_lane),
    .mac_out_valid(mac_out_valid), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [WW-1:0]   w_ref [N];
  logic [N*WW-1:0] exp_plane_q [$];
  logic [OW-1:0]   exp_res_q [$];
  bit              no_resp = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected lane vector for activation bit p under the reference weights.
  function automatic logic [N*WW-1:0] plane_of(input logic [N*AW-1:0] a, input int p);
    logic [N*WW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      if (a[k*AW + p]) r[k*WW +: WW] = w_ref[k];
    return r;
  endfunction

  function automatic int dot(input logic [N*AW-1:0] a);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(w_ref[k]) * int'(a[k*AW +: AW]);
    return s;
  endfunction

  function automatic int lanesum(input logic [N*WW-1:0] l);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(l[k*WW +: WW]);
    return s;
  endfunction

  // Monitor: planes, idle lanes, result handshakes and result stability.
  initial begin
    logic          prev_valid, prev_taken;
    logic [OW-1:0] prev_data;
    prev_valid = 1'b0; prev_taken = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        continue;
      end
      if (mac_valid !== 1'b1)          check("lane_zero_when_idle", mac_lane, 0);
      else if (exp_plane_q.size() == 0) check("unexpected_mac_valid", mac_valid, 0);
      else                              check("plane", mac_lane, exp_plane_q.pop_front());
      if (busy === 1'b1) check("act_ready_while_busy", act_ready, 0);
      if (res_valid === 1'b1) begin
        if (exp_res_q.size() == 0) check("unexpected_res_valid", res_valid, 0);
        else begin
          if (prev_valid && !prev_taken) check("res_data_stable", res_data, prev_data);
          if (res_ready === 1'b1) check("res_data", res_data, exp_res_q.pop_front());
        end
      end else if (prev_valid && !prev_taken) begin
        check("res_valid_held", res_valid, 1);
      end
      prev_valid = res_valid;
      prev_taken = res_ready;
      prev_data  = res_data;
    end
  end

  // Datapath stand-in: accumulates planes MSB first, answers after a random delay.
  initial begin
    int acc, n, d;
    mac_out_valid = 1'b0;
    mac_out       = '0;
    forever begin
      @(negedge clk);
      mac_out_valid = 1'b0;
      if (rst || mac_valid !== 1'b1) continue;
      acc = 0;
      n   = 0;
      while (mac_valid === 1'b1 && n < 8) begin
        acc = acc * 2 + lanesum(mac_lane);
        n++;
        mac_out_valid = 1'($urandom);
        mac_out       = OW'($urandom);
        @(negedge clk);
      end
      if (n != AW || rst) begin
        mac_out_valid = 1'b0;
        continue;
      end
      // gap cycle: a stray valid here must be ignored
      mac_out_valid = 1'($urandom);
      mac_out       = OW'($urandom);
      if (no_resp) continue;
      d = $urandom_range(0, 4);
      repeat (d) begin
        @(negedge clk);
        mac_out_valid = 1'b0;
      end
      @(negedge clk);
      mac_out_valid = 1'b1;
      mac_out       = OW'(acc);
      check("res_valid_before_capture", res_valid, 0);
      @(negedge clk);
      check("res_valid_latency", res_valid, 1);
      if ($urandom_range(0, 1) == 1) mac_out = OW'($urandom);
      else                           mac_out_valid = 1'b0;
    end
  end

  task automatic wr(input int addr, input int data, input bit exp_drop);
    cfg_we    = 1'b1;
    cfg_addr  = 5'(addr);
    cfg_wdata = WW'(data);
    if (!exp_drop) w_ref[addr] = WW'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_drop", cfg_drop, exp_drop);
  endtask

  task automatic submit(input logic [N*AW-1:0] a, input bit with_cfg, input int addr,
                        input int data, input bit expect_res);
    int n;
    if (with_cfg) begin
      cfg_we      = 1'b1;
      cfg_addr    = 5'(addr);
      cfg_wdata   = WW'(data);
      w_ref[addr] = WW'(data);
    end
    for (int p = AW - 1; p >= 0; p--) exp_plane_q.push_back(plane_of(a, p));
    if (expect_res) exp_res_q.push_back(OW'(dot(a)));
    act_valid = 1'b1;
    act_data  = a;
    n = 0;
    while (act_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", act_ready, 1);
    @(posedge clk); #1;
    act_valid = 1'b0;
    cfg_we    = 1'b0;
    act_data  = {$urandom, $urandom, $urandom, $urandom};
    check("send_start", mac_valid, 1);
  endtask

  task automatic wait_done(input bit rand_rr);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_res_q.size() != 0) && n < 200) begin
      res_ready = rand_rr ? 1'($urandom) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    res_ready = 1'b0;
    check("job_done_busy", busy, 0);
    check("job_done_results", exp_res_q.size(), 0);
  endtask

  initial begin
    logic [N*AW-1:0] a;
    int n;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    act_valid = 1'b0; act_data = '0; res_ready = 1'b0;
    for (int k = 0; k < N; k++) w_ref[k] = '0;
    #1;
    check("rst_act_ready", act_ready, 0);
    check("rst_mac_valid", mac_valid, 0);
    check("rst_mac_lane", mac_lane, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_cfg_drop", cfg_drop, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_act_ready", act_ready, 1);

    // all weights 1, all activations F: every plane is all-ones lanes, sum 480
    for (int k = 0; k < N; k++) wr(k, 1, 1'b0);
    submit({N{4'hF}}, 1'b0, 0, 0, 1'b1);
    wait_done(1'b1);

    // weight k%16, activations A: planes w,0,w,0
    for (int k = 0; k < N; k++) wr(k, k % 16, 1'b0);
    submit({N{4'hA}}, 1'b0, 0, 0, 1'b1);
    wait_done(1'b1);

    // random weights and activations
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 5; i++) wr($urandom_range(0, N - 1), $urandom_range(0, 15), 1'b0);
      submit({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 0, 1'b1);
      wait_done(1'b1);
    end

    // back-pressure: hold res_ready low for 10 cycles in HOLD
    submit({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 0, 1'b1);
    n = 0;
    while (res_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_reached", res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_res_valid", res_valid, 1);
      check("hold_act_ready", act_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("release_busy", busy, 0);
    check("release_res_valid", res_valid, 0);
    check("release_act_ready", act_ready, 1);

    // write on accept edge is used; write during SEND is dropped
    a = {$urandom, $urandom, $urandom, $urandom};
    a[15:12] = 4'hF;
    submit(a, 1'b1, 3, 9, 1'b1);
    wr(3, 7, 1'b1);
    @(posedge clk); #1;
    check("cfg_drop_one_cycle", cfg_drop, 0);
    wait_done(1'b1);
    submit({N{4'hF}}, 1'b0, 0, 0, 1'b1);
    wait_done(1'b1);

    // timeout: datapath never answers
    no_resp = 1'b1;
    submit({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("pre_timeout_err", timeout_err, 0);
    check("pre_timeout_busy", busy, 1);
    @(posedge clk); #1;
    check("timeout_err_set", timeout_err, 1);
    check("timeout_act_ready", act_ready, 1);
    check("timeout_busy", busy, 0);
    no_resp = 1'b0;
    submit({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 0, 1'b1);
    wait_done(1'b1);
    check("timeout_err_sticky", timeout_err, 1);

    // reset in the second SEND cycle
    submit({N{4'hF}}, 1'b0, 0, 0, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_mac_valid", mac_valid, 0);
    check("rst_mid_mac_lane", mac_lane, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_res_valid", res_valid, 0);
    exp_plane_q.delete();
    exp_res_q.delete();
    for (int k = 0; k < N; k++) w_ref[k] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_timeout_clr", timeout_err, 0);
    submit({N{4'hF}}, 1'b0, 0, 0, 1'b1);
    wait_done(1'b1);
    submit({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 0, 1'b1);
    wait_done(1'b1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
